uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive front end between the board's `UART_RXD` pin and the Yrv core's UART/MMIO receive path. It synchronises the raw serial line and recovers 8N1 frames by 16x oversampling. Received bytes are buffered in a small FIFO and presented to the core on a ready/valid interface, with sticky framing-error and overrun flags.

## Interface
Parameters:
- `CLOCK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 115200, line rate.
- `FIFO_DEPTH`, 8, buffered bytes; power of two, ≥2.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  raw asynchronous serial input; idle high.
- `io_data`  out  8  FIFO head byte.
- `io_valid`  out  1  FIFO non-empty.
- `io_ready`  in  1  consumer accepts head this cycle.
- `io_count`  out  clog2(FIFO_DEPTH)+1  bytes held.
- `io_frameError`  out  1  sticky; stop bit sampled low.
- `io_overrun`  out  1  sticky; byte dropped because FIFO full.
- `io_clearErrors`  in  1  clears both sticky flags.

## Operation
- Synchroniser: 2 flops, reset to 1. All decisions use the second flop (`rx_s`).
- Prescaler: DIV = (CLOCK_HZ + 8·BAUD) / (16·BAUD), integer. Counter 0..DIV-1, free-running, reset 0. `tick` is asserted when counter == DIV-1.
- FSM changes state only on `tick`. Reset state is IDLE with `armed`=0.
  - IDLE: when `rx_s`=1, set `armed`. When `armed` and `rx_s`=0, go to START with `sub`=0.
  - START: at `sub`=7 (mid start bit), sample `rx_s`. If 1, treat as a false start and go to IDLE. If 0, go to DATA with `sub`=0, `bit`=0.
  - DATA: every 16 ticks (`sub`=15), shift `rx_s` into the shift register LSB first. After bit 7, go to STOP.
  - STOP: at `sub`=15, sample `rx_s`.
    - 1: push the byte.
    - 0: set `io_frameError`, discard the byte, clear `armed`.
    - Either way, go to IDLE.
- FIFO: show-ahead. `io_data` = head entry. Pop when `io_valid & io_ready`.
  - Push while full and no pop: drop the byte and set `io_overrun`.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: cannot occur, since `io_valid`=0.
  - Pointers wrap modulo FIFO_DEPTH.
- `io_clearErrors` and a same-cycle error set: set wins.
- `io_data` when empty: last head value; 0 after reset.

## Timing
- Reset values: `io_valid`=0, `io_data`=0, `io_count`=0, `io_frameError`=0, `io_overrun`=0. Synchroniser=1, FSM=IDLE, `armed`=0.
- Reset mid-frame: the partial byte is lost. Reception resumes only after `rx_s` is seen high on a tick.
- Pin-to-`rx_s` latency: 2 clocks. Start detection lags by up to DIV additional clocks because of tick granularity.
- Push occurs on the STOP sampling tick. `io_valid`/`io_count` update on the next clock edge.
- Pop: `io_count` decrements and the next head appears on the clock after `valid&ready`.
- Sticky flags assert on the clock after the causing event. They clear on the clock after `io_clearErrors`.
- `io_count` never exceeds FIFO_DEPTH.

## Test plan
Bench uses CLOCK_HZ=3_200_000, BAUD=100_000, so DIV=2 and 1 bit = 32 clocks.
- Reset, hold `rx`=1 for 64 clocks, send 0x55 with `io_ready`=0 -> `io_valid`=1, `io_data`=0x55, `io_count`=1, both flags 0. Then assert `io_ready` for 1 cycle -> `io_valid`=0, `io_count`=0.
- `rx` low for 8 clocks, then high -> no push, `io_count`=0, FSM back in IDLE. A following 0xC3 frame is received intact.
- Send 0xA3 with stop bit 0 -> no push, `io_frameError`=1 and stays 1. Pulse `io_clearErrors` -> 0. After `rx` returns high, 0x3A is received correctly.
- `io_ready`=0, send 0x00..0x08 (9 frames) -> `io_count`=8, `io_overrun`=1. Popping returns 0x00..0x07 in order, then `io_valid`=0.
- FIFO full, `io_ready` pulsed on the exact push cycle of byte 0x77 -> `io_overrun` stays 0, `io_count` stays 8, 0x77 is the last byte popped.
- Assert `reset` for 1 clock midway through the data bits of 0xF0 -> all outputs reset next clock, 0xF0 never appears. Next frame 0x0F is received as the only byte.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Consumer-side bundle of the UART receive front end.
//   master: the receiver. Drives the head byte, valid, fill count and the
//           sticky error flags. Samples ready and clearErrors.
//   slave : the consumer (core MMIO path). Drives ready and clearErrors.
// FIFO_DEPTH must match the receiver so that io_count has the same width.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    io_data;
    logic          io_valid;
    logic          io_ready;
    logic [CW-1:0] io_count;
    logic          io_frameError;
    logic          io_overrun;
    logic          io_clearErrors;

    modport master (
        output io_data,
        output io_valid,
        output io_count,
        output io_frameError,
        output io_overrun,
        input  io_ready,
        input  io_clearErrors
    );

    modport slave (
        input  io_data,
        input  io_valid,
        input  io_count,
        input  io_frameError,
        input  io_overrun,
        output io_ready,
        output io_clearErrors
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive front end for the UART_RXD pin. The raw line is synchronised, 8N1
// frames are recovered with 16x oversampling, and received bytes are queued
// in a show-ahead FIFO presented on a ready/valid interface. Sticky flags
// report framing errors (stop bit low) and overruns (byte dropped when full).
// Ports:
//   clock : system clock, all logic on the rising edge
//   reset : synchronous, active-high
//   rx    : raw asynchronous serial input, idle high
//   io    : uart_rx_fifo_if.master (data/valid/ready/count/error flags/clear)
module uart_rx_fifo #(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rx,
    uart_rx_fifo_if.master  io
);

    // Rounded division so the oversampling tick is as close to 16x BAUD as possible.
    localparam int DIV = (CLOCK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic          sync1_q, sync1_d;
    logic          rx_s_q, rx_s_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic          tick;

    state_e        state_q, state_d;
    logic          armed_q, armed_d;
    logic [3:0]    sub_q, sub_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push;
    logic          frame_err_set;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_q, head_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          full;
    logic          pop;
    logic          do_write;
    logic          overrun_set;

    always_comb begin
        sync1_d    = rx;
        rx_s_d     = sync1_q;
        prescale_d = (prescale_q == DIV_LAST) ? '0 : prescale_q + PW'(1);
        tick       = (prescale_q == DIV_LAST);
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; every transition is gated by the oversampling tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:  if (armed_q && !rx_s_q) state_d = START;
                START: if (sub_q == 4'd7) state_d = rx_s_q ? IDLE : DATA;
                DATA:  if (sub_q == 4'd15 && bit_q == 3'd7) state_d = STOP;
                STOP:  if (sub_q == 4'd15) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: sub-bit/bit counters, shift register, push and error strobes.
    // armed is cleared after a framing error so that a line stuck low (break)
    // cannot retrigger a start until it has been seen idle high again.
    always_comb begin
        armed_d       = armed_q;
        sub_d         = sub_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_err_set = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        sub_d = 4'd0;
                    end
                end
                START: begin
                    if (sub_q == 4'd7) begin
                        sub_d = 4'd0;
                        bit_d = 3'd0;
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
                DATA: begin
                    if (sub_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        sub_d   = 4'd0;
                        bit_d   = bit_q + 3'd1;
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
                STOP: begin
                    if (sub_q == 4'd15) begin
                        sub_d = 4'd0;
                        if (rx_s_q) begin
                            push = 1'b1;
                        end else begin
                            frame_err_set = 1'b1;
                            armed_d       = 1'b0;
                        end
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
                default: begin
                    sub_d = 4'd0;
                end
            endcase
        end
    end

    // FIFO control. A full FIFO still accepts a push when the head is popped
    // in the same cycle; only a push with no room and no pop is an overrun.
    // head_q holds the show-ahead byte so io_data keeps its last value when empty.
    always_comb begin
        full        = (count_q == DEPTH_C);
        pop         = (count_q != '0) && io.io_ready;
        do_write    = push && (!full || pop);
        overrun_set = push && full && !pop;
        rd_next     = rd_ptr_q + AW'(1);

        mem_d = mem_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = shift_q;
        end

        wr_ptr_d = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_next : rd_ptr_q;

        count_d = count_q;
        if (do_write && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_write && pop) begin
            count_d = count_q - CW'(1);
        end

        head_d = head_q;
        if (pop) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_next];
            end else if (do_write) begin
                head_d = shift_q;
            end
        end else if (do_write && count_q == '0) begin
            head_d = shift_q;
        end

        frame_err_d = frame_err_set ? 1'b1 : (io.io_clearErrors ? 1'b0 : frame_err_q);
        overrun_d   = overrun_set   ? 1'b1 : (io.io_clearErrors ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            prescale_q  <= '0;
            armed_q     <= 1'b0;
            sub_q       <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= 8'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            prescale_q  <= prescale_d;
            armed_q     <= armed_d;
            sub_q       <= sub_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign io.io_data       = head_q;
    assign io.io_valid      = (count_q != '0);
    assign io.io_count      = count_q;
    assign io.io_frameError = frame_err_q;
    assign io.io_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo at CLOCK_HZ=3.2 MHz, BAUD=100 kbaud
// (DIV=2, 32 clocks per bit). Expected bytes are queued when each frame is
// issued; a monitor pops and compares on every valid&ready handshake.
module tb_uart_rx_fifo;

    localparam int CLOCK_HZ   = 3_200_000;
    localparam int BAUD       = 100_000;
    localparam int FIFO_DEPTH = 8;
    localparam int BIT_CLKS   = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) rxIf ();

    uart_rx_fifo #(
        .CLOCK_HZ   (CLOCK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .io    (rxIf.master)
    );

    always #5 clock = ~clock;

    // Model of the free-running prescaler phase: ticks on edges where this is odd.
    int unsigned cyc = 0;
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    logic [7:0] expQ [$];
    int passCount  = 0;
    int totalCount = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Scoreboard monitor: every accepted byte must be the oldest expected one.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (!reset && rxIf.io_valid && rxIf.io_ready) begin
                if (expQ.size() == 0) begin
                    totalCount++;
                    $display("[TB] FAIL unexpected pop: got 0x%0h, expected no byte", rxIf.io_data);
                end else begin
                    checkOutput("pop data", int'(rxIf.io_data), int'(expQ.pop_front()));
                end
            end
        end
    end

    // Sends one 8N1 frame plus one idle bit. Optionally pulses io_ready on
    // the exact clock of the stop-bit sampling tick (the push edge).
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                                 input bit expectPush, input bit readyAtPush);
        int unsigned startCyc;
        int unsigned pushCyc;
        if (expectPush) expQ.push_back(b);
        @(negedge clock);
        rx = 1'b0;
        startCyc = cyc;
        fork
            begin
                repeat (BIT_CLKS) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    rx = b[i];
                    repeat (BIT_CLKS) @(negedge clock);
                end
                rx = stopBit;
                repeat (BIT_CLKS) @(negedge clock);
                rx = 1'b1;
                repeat (BIT_CLKS) @(negedge clock);
            end
            begin
                if (readyAtPush) begin
                    // Start seen on the first tick at least 2 edges after the
                    // line falls, then 8 + 9*16 ticks to the stop sample.
                    pushCyc = startCyc + ((startCyc % 2 == 1) ? 2 : 3) + 304;
                    for (int k = 0; k < 1000 && cyc != pushCyc; k++) @(negedge clock);
                    if (cyc != pushCyc) begin
                        totalCount++;
                        $display("[TB] FAIL push-cycle wait: got cyc %0d, expected %0d", cyc, pushCyc);
                    end
                    rxIf.io_ready = 1'b1;
                    @(negedge clock);
                    rxIf.io_ready = 1'b0;
                end
            end
        join
    endtask

    task automatic popOne();
        @(negedge clock);
        rxIf.io_ready = 1'b1;
        @(negedge clock);
        rxIf.io_ready = 1'b0;
    endtask

    task automatic drainAll();
        for (int k = 0; k < 20 && rxIf.io_valid; k++) popOne();
        #1;
        checkOutput("drained valid", int'(rxIf.io_valid), 0);
        checkOutput("drained count", int'(rxIf.io_count), 0);
        checkOutput("scoreboard empty", expQ.size(), 0);
    endtask

    task automatic pulseClear();
        @(negedge clock);
        rxIf.io_clearErrors = 1'b1;
        @(negedge clock);
        rxIf.io_clearErrors = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rxIf.io_ready       = 1'b0;
        rxIf.io_clearErrors = 1'b0;

        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset valid", int'(rxIf.io_valid), 0);
        checkOutput("reset data", int'(rxIf.io_data), 0);
        checkOutput("reset count", int'(rxIf.io_count), 0);
        checkOutput("reset frameError", int'(rxIf.io_frameError), 0);
        checkOutput("reset overrun", int'(rxIf.io_overrun), 0);
        reset = 1'b0;
        repeat (64) @(negedge clock);

        // Single byte held until read.
        applyStimulus(8'h55, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("0x55 valid", int'(rxIf.io_valid), 1);
        checkOutput("0x55 data", int'(rxIf.io_data), 8'h55);
        checkOutput("0x55 count", int'(rxIf.io_count), 1);
        checkOutput("0x55 frameError", int'(rxIf.io_frameError), 0);
        checkOutput("0x55 overrun", int'(rxIf.io_overrun), 0);
        popOne();
        #1;
        checkOutput("after pop valid", int'(rxIf.io_valid), 0);
        checkOutput("after pop count", int'(rxIf.io_count), 0);

        // False start: 8-clock glitch low.
        @(negedge clock);
        rx = 1'b0;
        repeat (8) @(negedge clock);
        rx = 1'b1;
        repeat (64) @(negedge clock);
        #1;
        checkOutput("glitch count", int'(rxIf.io_count), 0);
        applyStimulus(8'hC3, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("0xC3 count", int'(rxIf.io_count), 1);
        drainAll();

        // Framing error, sticky until cleared.
        applyStimulus(8'hA3, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bad stop count", int'(rxIf.io_count), 0);
        checkOutput("bad stop frameError", int'(rxIf.io_frameError), 1);
        repeat (40) @(negedge clock);
        #1;
        checkOutput("frameError sticky", int'(rxIf.io_frameError), 1);
        pulseClear();
        #1;
        checkOutput("frameError cleared", int'(rxIf.io_frameError), 0);
        applyStimulus(8'h3A, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("0x3A count", int'(rxIf.io_count), 1);
        checkOutput("0x3A data", int'(rxIf.io_data), 8'h3A);
        drainAll();

        // Overrun: ninth byte dropped.
        for (int i = 0; i < 9; i++) applyStimulus(8'(i), 1'b1, (i < 8), 1'b0);
        #1;
        checkOutput("full count", int'(rxIf.io_count), 8);
        checkOutput("full overrun", int'(rxIf.io_overrun), 1);
        checkOutput("full head", int'(rxIf.io_data), 8'h00);
        drainAll();
        pulseClear();
        #1;
        checkOutput("overrun cleared", int'(rxIf.io_overrun), 0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h10 + i), 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("refill count", int'(rxIf.io_count), 8);
        applyStimulus(8'h77, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("push+pop overrun", int'(rxIf.io_overrun), 0);
        checkOutput("push+pop count", int'(rxIf.io_count), 8);
        checkOutput("push+pop head", int'(rxIf.io_data), 8'h11);
        drainAll();

        // Reset in the middle of a frame flushes everything.
        applyStimulus(8'h99, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("pre-reset count", int'(rxIf.io_count), 1);
        checkOutput("pre-reset data", int'(rxIf.io_data), 8'h99);
        fork
            applyStimulus(8'hF0, 1'b1, 1'b0, 1'b0);
            begin
                repeat (BIT_CLKS * 5 + 16) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                #1;
                checkOutput("mid reset valid", int'(rxIf.io_valid), 0);
                checkOutput("mid reset data", int'(rxIf.io_data), 0);
                checkOutput("mid reset count", int'(rxIf.io_count), 0);
                checkOutput("mid reset frameError", int'(rxIf.io_frameError), 0);
                checkOutput("mid reset overrun", int'(rxIf.io_overrun), 0);
            end
        join
        repeat (32) @(negedge clock);
        #1;
        checkOutput("post reset count", int'(rxIf.io_count), 0);
        applyStimulus(8'h0F, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("0x0F count", int'(rxIf.io_count), 1);
        checkOutput("0x0F data", int'(rxIf.io_data), 8'h0F);
        drainAll();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
